// File: rtl/csr_trap_unit.sv
// csr_trap_unit: machine-mode CSR file and trap sequencer driving pipeline flush and fetch redirect
//   clk, rst            clock; synchronous active-low reset
//   wb_wr_csr/waddr/wdata  WB-stage CSR write commit (address bits [11:0] decoded)
//   ctrl_raddr_csr      combinational CSR read address -> csr_rdata
//   exc_req/cause/pc    synchronous exception from MEM; exc_pc is also the interrupt resume PC
//   mret_req            mret reached MEM
//   irq_timer           level timer interrupt (mip.MTIP)
//   retire              instruction-retired strobe for minstret
//   pipe_flush          flush every pipeline register (FLUSH state)
//   redirect_valid/pc   fetch redirect to the latched trap target (REDIR state)
module csr_trap_unit #(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0100,
  parameter bit CNT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_wr_csr,
  input  logic [31:0] wb_waddr_csr,
  input  logic [31:0] wb_wdata_csr,
  input  logic [31:0] ctrl_raddr_csr,
  output logic [31:0] csr_rdata,
  input  logic        exc_req,
  input  logic [31:0] exc_cause,
  input  logic [31:0] exc_pc,
  input  logic        mret_req,
  input  logic        irq_timer,
  input  logic        retire,
  output logic        pipe_flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);
  typedef enum logic [1:0] {IDLE, FLUSH, REDIR} state_e;
  state_e state_q, state_d;
  logic mie_q, mie_d, mpie_q, mpie_d, mtie_q, mtie_d, mode_q, mode_d;
  logic [29:0] base_q, base_d, mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d, target_q, target_d;
  logic [63:0] mcycle_q, mcycle_d, minstret_q, minstret_d;
  logic [11:0] wa, ra;
  logic idle, take_exc, take_mret, take_irq, unused;
  assign wa = wb_waddr_csr[11:0];
  assign ra = ctrl_raddr_csr[11:0];
  assign idle = state_q == IDLE;
  assign take_exc = idle & exc_req;
  assign take_mret = idle & ~exc_req & mret_req;
  assign take_irq = idle & ~exc_req & ~mret_req & irq_timer & mtie_q & mie_q;
  assign redirect_pc = target_q;
  assign unused = ^{wb_waddr_csr[31:12], ctrl_raddr_csr[31:12], exc_pc[1:0]};
  always_comb begin
    csr_rdata = 32'd0;
    case (ra)
      12'h300: csr_rdata = {19'd0, 2'b11, 3'd0, mpie_q, 3'd0, mie_q, 3'd0};
      12'h304: csr_rdata = {24'd0, mtie_q, 7'd0};
      12'h344: csr_rdata = {24'd0, irq_timer, 7'd0};
      12'h305: csr_rdata = {base_q, 1'b0, mode_q};
      12'h341: csr_rdata = {mepc_q, 2'b00};
      12'h342: csr_rdata = mcause_q;
      12'hB00: csr_rdata = mcycle_q[31:0];
      12'hB80: csr_rdata = mcycle_q[63:32];
      12'hB02: csr_rdata = minstret_q[31:0];
      12'hB82: csr_rdata = minstret_q[63:32];
      default: csr_rdata = 32'd0;
    endcase
  end
  always_comb begin
    state_d = IDLE;
    pipe_flush = 1'b0;
    redirect_valid = 1'b0;
    case (state_q)
      IDLE: state_d = (take_exc | take_mret | take_irq) ? FLUSH : IDLE;
      FLUSH: begin
        state_d = REDIR;
        pipe_flush = 1'b1;
      end
      REDIR: redirect_valid = 1'b1;
      default: state_d = IDLE;
    endcase
  end
  // WB writes first; trap updates afterwards so they win on shared bits
  always_comb begin
    mie_d = mie_q;
    mpie_d = mpie_q;
    mtie_d = mtie_q;
    mode_d = mode_q;
    base_d = base_q;
    mepc_d = mepc_q;
    mcause_d = mcause_q;
    target_d = target_q;
    mcycle_d = CNT_EN ? mcycle_q + 64'd1 : mcycle_q;
    minstret_d = (CNT_EN && retire) ? minstret_q + 64'd1 : minstret_q;
    if (wb_wr_csr) begin
      case (wa)
        12'h300: begin
          mie_d = wb_wdata_csr[3];
          mpie_d = wb_wdata_csr[7];
        end
        12'h304: mtie_d = wb_wdata_csr[7];
        12'h305: begin
          base_d = wb_wdata_csr[31:2];
          mode_d = wb_wdata_csr[0];
        end
        12'h341: mepc_d = wb_wdata_csr[31:2];
        12'h342: mcause_d = wb_wdata_csr;
        12'hB00: mcycle_d = {mcycle_q[63:32], wb_wdata_csr};
        12'hB80: mcycle_d = {wb_wdata_csr, mcycle_q[31:0]};
        12'hB02: minstret_d = {minstret_q[63:32], wb_wdata_csr};
        12'hB82: minstret_d = {wb_wdata_csr, minstret_q[31:0]};
        default: ;
      endcase
    end
    if (take_exc | take_irq) begin
      mepc_d = exc_pc[31:2];
      mpie_d = mie_q;
      mie_d = 1'b0;
      mcause_d = take_exc ? exc_cause : 32'h8000_0007;
      // vectored mode offsets only interrupts: cause 7 -> base + 4*7
      target_d = {(take_irq && mode_q) ? base_q + 30'd7 : base_q, 2'b00};
    end
    if (take_mret) begin
      mie_d = mpie_q;
      mpie_d = 1'b1;
      target_d = {mepc_q, 2'b00};
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      mie_q <= 1'b0;
      mpie_q <= 1'b0;
      mtie_q <= 1'b0;
      mode_q <= RESET_MTVEC[0];
      base_q <= RESET_MTVEC[31:2];
      mepc_q <= 30'd0;
      mcause_q <= 32'd0;
      target_q <= 32'd0;
      mcycle_q <= 64'd0;
      minstret_q <= 64'd0;
    end else begin
      state_q <= state_d;
      mie_q <= mie_d;
      mpie_q <= mpie_d;
      mtie_q <= mtie_d;
      mode_q <= mode_d;
      base_q <= base_d;
      mepc_q <= mepc_d;
      mcause_q <= mcause_d;
      target_q <= target_d;
      mcycle_q <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end
endmodule

// File: tb/tb_csr_trap_unit.sv
// tb_csr_trap_unit: directed vectors with hand-computed expectations for csr_trap_unit
module tb_csr_trap_unit;
  logic clk = 1'b0;
  logic rst, wb_wr_csr, mret_req, irq_timer, retire, exc_req;
  logic [31:0] wb_waddr_csr, wb_wdata_csr, ctrl_raddr_csr, exc_cause, exc_pc;
  logic [31:0] csr_rdata, redirect_pc;
  logic pipe_flush, redirect_valid;
  int n_vec = 0;
  int n_bad = 0;
  csr_trap_unit dut (
    .clk(clk), .rst(rst),
    .wb_wr_csr(wb_wr_csr), .wb_waddr_csr(wb_waddr_csr), .wb_wdata_csr(wb_wdata_csr),
    .ctrl_raddr_csr(ctrl_raddr_csr), .csr_rdata(csr_rdata),
    .exc_req(exc_req), .exc_cause(exc_cause), .exc_pc(exc_pc),
    .mret_req(mret_req), .irq_timer(irq_timer), .retire(retire),
    .pipe_flush(pipe_flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );
  always #10 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
    ctrl_raddr_csr = {20'd0, a};
    #1;
    chk(tag, csr_rdata, exp);
  endtask
  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    wb_wr_csr = 1'b1;
    wb_waddr_csr = {20'd0, a};
    wb_wdata_csr = d;
    tick();
    wb_wr_csr = 1'b0;
  endtask
  task automatic outs(input string tag, input logic f, input logic v, input logic [31:0] pc);
    chk({tag, ".flush"}, 32'(pipe_flush), 32'(f));
    chk({tag, ".rv"}, 32'(redirect_valid), 32'(v));
    chk({tag, ".rpc"}, redirect_pc, pc);
  endtask
  initial begin
    rst = 1'b0; wb_wr_csr = 1'b0; wb_waddr_csr = '0; wb_wdata_csr = '0; ctrl_raddr_csr = '0;
    exc_req = 1'b0; exc_cause = '0; exc_pc = '0; mret_req = 1'b0; irq_timer = 1'b0; retire = 1'b0;
    tick();
    tick();
    outs("rst", 1'b0, 1'b0, 32'h0);
    rd("rst.mstatus", 12'h300, 32'h0000_1800);
    rd("rst.mtvec", 12'h305, 32'h0000_0100);
    rd("rst.mepc", 12'h341, 32'h0);
    rd("rst.mcause", 12'h342, 32'h0);
    rd("rst.mcycle", 12'hB00, 32'h0);
    rst = 1'b1;
    wr(12'h305, 32'h0000_0201);
    rd("mtvec", 12'h305, 32'h0000_0201);
    wr(12'h305, 32'hFFFF_FFFF);
    rd("mtvec.b1", 12'h305, 32'hFFFF_FFFD);
    wr(12'h305, 32'h0000_0100);
    wr(12'h123, 32'hFFFF_FFFF);
    rd("unmapped", 12'h123, 32'h0);
    wr(12'h304, 32'hFFFF_FFFF);
    rd("mie", 12'h304, 32'h0000_0080);
    irq_timer = 1'b1;
    rd("mip", 12'h344, 32'h0000_0080);
    tick();
    chk("irq.gated", 32'(pipe_flush), 32'h0);
    irq_timer = 1'b0;
    wr(12'h304, 32'h0);
    wr(12'h344, 32'hFFFF_FFFF);
    rd("mip.ro", 12'h344, 32'h0);
    wr(12'h341, 32'h1234_5677);
    rd("mepc", 12'h341, 32'h1234_5674);
    wr(12'h342, 32'hDEAD_BEEF);
    wb_wr_csr = 1'b1; wb_waddr_csr = 32'h342; wb_wdata_csr = 32'h5;
    rd("prewrite", 12'h342, 32'hDEAD_BEEF);
    tick();
    wb_wr_csr = 1'b0;
    rd("postwrite", 12'h342, 32'h5);
    wr(12'h300, 32'hFFFF_FF77);
    rd("mstatus.w", 12'h300, 32'h0000_1800);
    wr(12'h300, 32'h0000_0008);
    rd("mstatus.mie", 12'h300, 32'h0000_1808);
    exc_req = 1'b1; exc_cause = 32'h2; exc_pc = 32'h0000_0044;
    tick();
    exc_req = 1'b0;
    outs("exc.f", 1'b1, 1'b0, 32'h0000_0100);
    tick();
    outs("exc.r", 1'b0, 1'b1, 32'h0000_0100);
    tick();
    outs("exc.i", 1'b0, 1'b0, 32'h0000_0100);
    rd("exc.mepc", 12'h341, 32'h0000_0044);
    rd("exc.mcause", 12'h342, 32'h2);
    rd("exc.mstatus", 12'h300, 32'h0000_1880);
    wr(12'h300, 32'h0000_0008);
    wr(12'h304, 32'h0000_0080);
    wr(12'h305, 32'h0000_0201);
    irq_timer = 1'b1; exc_pc = 32'h0000_0080;
    tick();
    irq_timer = 1'b0;
    outs("irq.f", 1'b1, 1'b0, 32'h0000_021C);
    tick();
    outs("irq.r", 1'b0, 1'b1, 32'h0000_021C);
    tick();
    rd("irq.mcause", 12'h342, 32'h8000_0007);
    rd("irq.mstatus", 12'h300, 32'h0000_1880);
    rd("irq.mepc", 12'h341, 32'h0000_0080);
    mret_req = 1'b1;
    tick();
    mret_req = 1'b0;
    chk("mret.f", 32'(pipe_flush), 32'h1);
    tick();
    outs("mret.r", 1'b0, 1'b1, 32'h0000_0080);
    tick();
    rd("mret.mstatus", 12'h300, 32'h0000_1888);
    exc_req = 1'b1; exc_cause = 32'hB; exc_pc = 32'h0000_0200; mret_req = 1'b1;
    wb_wr_csr = 1'b1; wb_waddr_csr = 32'h342; wb_wdata_csr = 32'h77;
    tick();
    exc_req = 1'b0; mret_req = 1'b0; wb_wr_csr = 1'b0;
    tick();
    outs("prio.r", 1'b0, 1'b1, 32'h0000_0200);
    tick();
    rd("prio.mcause", 12'h342, 32'hB);
    rd("prio.mepc", 12'h341, 32'h0000_0200);
    rd("prio.mstatus", 12'h300, 32'h0000_1880);
    wr(12'hB00, 32'hFFFF_FFFF);
    wr(12'hB80, 32'h0);
    rd("mcyc.hi0", 12'hB80, 32'h0);
    rd("mcyc.lo0", 12'hB00, 32'hFFFF_FFFF);
    tick();
    rd("mcyc.hi1", 12'hB80, 32'h1);
    rd("mcyc.lo1", 12'hB00, 32'h0);
    wr(12'hB02, 32'd10);
    wr(12'hB82, 32'h0);
    retire = 1'b1;
    repeat (5) tick();
    retire = 1'b0;
    rd("minstret", 12'hB02, 32'd15);
    wr(12'hB02, 32'hFFFF_FFFF);
    wr(12'hB82, 32'hFFFF_FFFF);
    retire = 1'b1;
    tick();
    retire = 1'b0;
    rd("wrap.lo", 12'hB02, 32'h0);
    rd("wrap.hi", 12'hB82, 32'h0);
    exc_req = 1'b1; exc_cause = 32'h4; exc_pc = 32'h0000_0300;
    tick();
    exc_req = 1'b0;
    chk("abort.f", 32'(pipe_flush), 32'h1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    outs("abort.0", 1'b0, 1'b0, 32'h0);
    tick();
    outs("abort.1", 1'b0, 1'b0, 32'h0);
    rd("abort.mtvec", 12'h305, 32'h0000_0100);
    exc_req = 1'b1; exc_cause = 32'h1; exc_pc = 32'h0000_0040;
    tick();
    exc_cause = 32'h9; exc_pc = 32'h0000_0400;
    tick();
    chk("ign.r", 32'(redirect_valid), 32'h1);
    tick();
    exc_req = 1'b0;
    outs("ign.i", 1'b0, 1'b0, 32'h0000_0100);
    rd("ign.mepc", 12'h341, 32'h0000_0040);
    rd("ign.mcause", 12'h342, 32'h1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
